// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII receive frame controller:
// FSM state encoding, CRC-32 constants and frame_err bit positions.
package ether_pkg;

  typedef enum logic [2:0] {
    ST_SKIP,
    ST_IDLE,
    ST_DEST,
    ST_BODY,
    ST_DROP,
    ST_CHECK
  } state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int ERR_ADDR  = 3;
  localparam int ERR_ALIGN = 2;
  localparam int ERR_LEN   = 1;
  localparam int ERR_CRC   = 0;

endpackage

// File: rtl/ether_frame_ctrl_crc32.sv
// Reflected CRC-32 accumulator: one byte per enabled cycle, LSB first,
// no final XOR so a good frame (FCS included) leaves the fixed residue.
module crc32_byte
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  logic [31:0] crc_q;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= crc_upd(crc_q, din);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ether_frame_ctrl.sv
// RMII receive frame controller: dibit-to-byte assembly, destination filter,
// length/alignment/FCS checks and a one-cycle commit/discard status per frame.
module ether_frame_ctrl
  import ether_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  input  logic        promisc,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [3:0]  frame_err,
  output logic [10:0] frame_len,
  output logic [15:0] drop_count
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  state_e      state_q;
  logic [7:0]  sr_q;
  logic [1:0]  phase_q;
  logic [10:0] cnt_q;
  logic        promisc_q, mac_ok_q, bc_ok_q, addr_pass_q, align_q;
  logic        byte_vld_q;
  logic [7:0]  byte_q;
  logic        out_valid_q, frame_done_q, frame_ok_q;
  logic [3:0]  frame_err_q;
  logic [10:0] frame_len_q;
  logic [15:0] drop_q;
  logic [31:0] crc;

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    logic [47:0] s;
    s = MAC_ADDR << {idx, 3'b000};
    return s[47:40];
  endfunction

  logic [7:0] byte_d;
  logic       in_frame, byte_done, mac_hit, bc_hit, match, crc_init;
  logic [3:0] err_d;

  assign byte_d    = {axiid, sr_q[7:2]};
  assign in_frame  = (state_q == ST_DEST) || (state_q == ST_BODY) || (state_q == ST_DROP);
  assign byte_done = in_frame && axiiv && (phase_q == 2'd3);
  assign mac_hit   = mac_ok_q && (byte_d == mac_byte(cnt_q[2:0]));
  assign bc_hit    = bc_ok_q && (byte_d == 8'hFF);
  assign match     = mac_hit || bc_hit || promisc_q;
  assign crc_init  = (state_q == ST_IDLE) && axiiv;

  always_comb begin
    err_d            = 4'h0;
    err_d[ERR_CRC]   = (crc != CRC_RESIDUE);
    err_d[ERR_LEN]   = (cnt_q < MIN_L) || (cnt_q > MAX_L);
    err_d[ERR_ALIGN] = align_q;
    err_d[ERR_ADDR]  = !addr_pass_q;
  end

  // The shift register holds only in-flight data and needs no reset.
  always_ff @(posedge clk) begin
    if (axiiv && (in_frame || state_q == ST_IDLE)) begin
      sr_q <= byte_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SKIP;
      phase_q      <= 2'd0;
      cnt_q        <= 11'd0;
      promisc_q    <= 1'b0;
      mac_ok_q     <= 1'b0;
      bc_ok_q      <= 1'b0;
      addr_pass_q  <= 1'b0;
      align_q      <= 1'b0;
      byte_vld_q   <= 1'b0;
      byte_q       <= 8'h00;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 4'h0;
      frame_len_q  <= 11'd0;
      drop_q       <= 16'h0000;
    end else begin
      byte_vld_q   <= byte_done;
      out_valid_q  <= byte_done && (state_q != ST_DROP);
      frame_done_q <= 1'b0;
      if (byte_done) begin
        byte_q <= byte_d;
        if (cnt_q != 11'h7FF) cnt_q <= cnt_q + 11'd1;
      end
      if (axiiv && in_frame) phase_q <= phase_q + 2'd1;

      case (state_q)
        ST_SKIP: if (!axiiv) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (axiiv) begin
            state_q     <= ST_DEST;
            phase_q     <= 2'd1;
            cnt_q       <= 11'd0;
            promisc_q   <= promisc;
            mac_ok_q    <= 1'b1;
            bc_ok_q     <= 1'b1;
            addr_pass_q <= 1'b0;
          end
        end
        ST_DEST: begin
          if (!axiiv) begin
            state_q <= ST_CHECK;
            align_q <= (phase_q != 2'd0);
          end else if (byte_done) begin
            mac_ok_q <= mac_hit;
            bc_ok_q  <= bc_hit;
            if (cnt_q == 11'd5) begin
              addr_pass_q <= match;
              state_q     <= match ? ST_BODY : ST_DROP;
            end
          end
        end
        ST_BODY, ST_DROP: begin
          if (!axiiv) begin
            state_q <= ST_CHECK;
            align_q <= (phase_q != 2'd0);
          end
        end
        ST_CHECK: begin
          frame_done_q <= 1'b1;
          frame_ok_q   <= (err_d == 4'h0);
          frame_err_q  <= err_d;
          frame_len_q  <= cnt_q;
          if ((err_d != 4'h0) && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_SKIP;
      endcase
    end
  end

  crc32_byte u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (byte_vld_q),
    .din  (byte_q),
    .crc  (crc)
  );

  assign out_valid  = out_valid_q;
  assign out_data   = byte_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign frame_len  = frame_len_q;
  assign drop_count = drop_q;

endmodule
